video_snapshot: RTL

VIDEO_SNAPSHOT -- requirements
Module: video_snapshot

---
 rtl/video_snapshot_pkg.sv | 22 ++
 rtl/video_snapshot_ram.sv | 30 +++
 rtl/video_snapshot.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/video_snapshot_pkg.sv
// Shared definitions for the video snapshot block: FSM state encoding,
// the abort command code, the default snapshot depth and the byte
// formatter that splits a 12-bit sample into its two response bytes.
package video_snapshot_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_TRIG = 2'd1;
    localparam state_t ST_CAPTURE   = 2'd2;
    localparam state_t ST_READY     = 2'd3;

    localparam logic [7:0] ABORT_CODE = 8'h00;

    localparam int MAX_SAMPLES_DEFAULT = 127;

    // High byte carries sample[11:8] in its low nibble, low byte carries sample[7:0].
    function automatic logic [7:0] sample_byte(input logic [11:0] s, input logic lo);
        return lo ? s[7:0] : {4'b0000, s[11:8]};
    endfunction

endpackage

// File: rtl/video_snapshot_ram.sv
// Snapshot sample buffer: simple dual-port RAM, one write port and one
// synchronous read port (one cycle read latency, contents not reset).
module snapshot_ram #(
    parameter int DEPTH = 127,
    parameter int DW    = 12,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/video_snapshot.sv
// Video snapshot: on a sample-count command, waits for the trigger,
// captures that many video samples into a buffer, then offers them to
// the command encoder as a show-ahead byte stream (two bytes per sample).
// Command byte 0x00 aborts from any state.
// Optional feature macro: VIDEO_SNAPSHOT_TRIG_EN -- when defined, capture
// is armed by a rising edge of hd; otherwise capture starts right away.
module video_snapshot
    import video_snapshot_pkg::*;
#(
    parameter int MAX_SAMPLES = MAX_SAMPLES_DEFAULT,
    parameter int DW          = 12
) (
    input  logic          sys_clk,
    input  logic          n_rst,
    input  logic [7:0]    master_data,
    input  logic          in_ena,
    input  logic [DW-1:0] q_data,
    input  logic          q_valid,
    input  logic          hd,
    input  logic          rdreq,
    output logic [7:0]    out_data,
    output logic          have_msg,
    output logic [7:0]    len,
    output logic          busy
);

    localparam int AW = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;

    state_t state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic [7:0] len_q, len_d;
    logic have_msg_q, have_msg_d;
    logic fwd_q, fwd_d;
    logic [DW-1:0] fwd_data_q;

    logic abort;
    logic trig_hit;
    logic capture_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] cur_sample;
    logic [11:0] cur_sample12;

`ifdef VIDEO_SNAPSHOT_TRIG_EN
    logic hd_q;

    // Previous hd level for rising-edge detection.
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            hd_q <= 1'b0;
        end else begin
            hd_q <= hd;
        end
    end

    assign trig_hit = hd && !hd_q;
`else
    logic unused_hd;
    assign unused_hd = hd;
    assign trig_hit  = 1'b1;
`endif

    assign abort = in_ena && (master_data == ABORT_CODE);

    // A write happens in CAPTURE on every q_valid; in WAIT_TRIG only when the
    // trigger edge and a sample coincide (without the trigger feature WAIT_TRIG
    // just hands over to CAPTURE and takes no sample).
`ifdef VIDEO_SNAPSHOT_TRIG_EN
    assign capture_en = !abort && q_valid &&
                        ((state_q == ST_CAPTURE) || ((state_q == ST_WAIT_TRIG) && trig_hit));
`else
    assign capture_en = !abort && q_valid && (state_q == ST_CAPTURE);
`endif

    assign wr_addr = wr_ptr_q[AW-1:0];
    // Read address follows the next-cycle byte pointer so the RAM output
    // already holds the current sample when the byte is presented.
    assign rd_addr = rd_byte_d[AW:1];

    // Next-state and pointer logic; abort overrides everything else.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_byte_d  = rd_byte_q;
        len_d      = len_q;
        have_msg_d = have_msg_q;

        if (abort) begin
            state_d    = ST_IDLE;
            count_d    = 8'd0;
            wr_ptr_d   = 8'd0;
            rd_byte_d  = 8'd0;
            len_d      = 8'd0;
            have_msg_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_ena) begin
                        count_d  = (master_data > 8'(MAX_SAMPLES)) ? 8'(MAX_SAMPLES) : master_data;
                        wr_ptr_d = 8'd0;
                        state_d  = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state_d = ST_CAPTURE;
                end
                default: begin
                    if (rdreq && have_msg_q) begin
                        if (rd_byte_q == len_q - 8'd1) begin
                            state_d    = ST_IDLE;
                            rd_byte_d  = 8'd0;
                            len_d      = 8'd0;
                            have_msg_d = 1'b0;
                        end else begin
                            rd_byte_d = rd_byte_q + 8'd1;
                        end
                    end
                end
            endcase

            if (capture_en) begin
                wr_ptr_d = wr_ptr_q + 8'd1;
                if (wr_ptr_q + 8'd1 == count_q) begin
                    state_d    = ST_READY;
                    have_msg_d = 1'b1;
                    len_d      = {count_q[6:0], 1'b0};
                    rd_byte_d  = 8'd0;
                end
            end
        end
    end

    // Forward a sample written to the address being read in the same cycle,
    // since the RAM returns the old contents on such a collision.
    always_comb begin
        fwd_d = capture_en && (wr_addr == rd_addr);
    end

    // Control registers.
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 8'd0;
            wr_ptr_q   <= 8'd0;
            rd_byte_q  <= 8'd0;
            len_q      <= 8'd0;
            have_msg_q <= 1'b0;
            fwd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_byte_q  <= rd_byte_d;
            len_q      <= len_d;
            have_msg_q <= have_msg_d;
            fwd_q      <= fwd_d;
        end
    end

    // Forwarded sample data (no reset needed, qualified by fwd_q).
    always_ff @(posedge sys_clk) begin
        fwd_data_q <= q_data;
    end

    snapshot_ram #(
        .DEPTH (MAX_SAMPLES),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (sys_clk),
        .we    (capture_en),
        .waddr (wr_addr),
        .wdata (q_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Current sample zero-extended to 12 bits and split into the current byte.
    always_comb begin
        cur_sample   = fwd_q ? fwd_data_q : ram_rdata;
        cur_sample12 = '0;
        cur_sample12[DW-1:0] = cur_sample;
        out_data = have_msg_q ? sample_byte(cur_sample12, rd_byte_q[0]) : 8'h00;
    end

    assign have_msg = have_msg_q;
    assign len      = len_q;
    assign busy     = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);

endmodule
